// File: rtl/reg16x32_write_port_pkg.sv
// Shared constants, FSM encoding and write payload type for the 16x32 register bank write port.
package reg16x32_write_port_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned Q_W    = DEPTH * WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wr_req_t;

endpackage

// File: rtl/reg16x32_write_port_if.sv
// Write/clear handshake and flat register-contents bus between a producer and the register bank.
interface reg16x32_write_port_if;
    import reg16x32_write_port_pkg::*;

    logic           wr_valid;
    logic           wr_ready;
    wr_req_t        wr_req;
    logic           clr_req;
    logic           busy;
    logic           clr_done;
    logic [Q_W-1:0] q;

    modport master (
        output wr_valid, wr_req, clr_req,
        input  wr_ready, busy, clr_done, q
    );

    modport slave (
        input  wr_valid, wr_req, clr_req,
        output wr_ready, busy, clr_done, q
    );

endinterface

// File: rtl/reg16x32_write_port_decoder_4x16.sv
// 4-to-16 one-hot decoder with enable; all-zero output when disabled.
module decoder_4x16
    import reg16x32_write_port_pkg::*;
(
    input  logic [ADDR_W-1:0] sel_i,
    input  logic              en_i,
    output logic [DEPTH-1:0]  onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg16x32_write_port.sv
// Write side of the 16x32 register bank: handshake writes, sequential 16-cycle clear,
// and the flat Q bus feeding the read mux inputs I0..I15.
module reg16x32_write_port
    import reg16x32_write_port_pkg::*;
#(
    parameter bit HARD_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg16x32_write_port_if.slave  bus
);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_done_q, clr_done_d;
    logic              clearing;
    logic              wr_fire;
    logic [ADDR_W-1:0] dec_sel;
    logic              dec_en;
    logic [DEPTH-1:0]  en;
    logic [WIDTH-1:0]  reg_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];

    assign clearing     = (state_q == ST_CLEAR);
    assign bus.wr_ready = (state_q == ST_IDLE) && !bus.clr_req;
    assign bus.busy     = clearing;
    assign bus.clr_done = clr_done_q;
    assign wr_fire      = bus.wr_valid && bus.wr_ready;

    // One decoder serves both paths: the clear counter owns it while clearing.
    assign dec_sel = clearing ? cnt_q : bus.wr_req.addr;
    assign dec_en  = clearing || wr_fire;
    assign reg_d   = clearing ? '0 : bus.wr_req.data;

    decoder_4x16 u_dec (
        .sel_i    (dec_sel),
        .en_i     (dec_en),
        .onehot_o (en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // Counter wrap 15->0 coincides with the return to IDLE.
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        localparam bit LOCKED = HARD_ZERO && (i == 0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs_q[i] <= '0;
            end else if (en[i] && !LOCKED) begin
                regs_q[i] <= reg_d;
            end
        end

        assign bus.q[i*WIDTH +: WIDTH] = regs_q[i];
    end

endmodule
